// File: rtl/sram_like_resp_pkg.sv
// Shared types and defaults for the SRAM-like responder.
// Holds size encodings and response-queue entry layout.
package sram_like_resp_pkg;

   localparam int DEF_MEM_AW = 10;
   localparam int DEF_QDEPTH = 4;
   localparam int DATA_W     = 32;
   localparam int ENTRY_W    = DATA_W + 1;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef struct packed {
      logic              is_read;
      logic [DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/sram_like_resp_if.sv
// Request/response bus between initiator and responder.
// Master drives requests, slave answers with addr_ok/data_ok.
interface sram_like_resp_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_resp_fifo.sv
// Synchronous FIFO holding accepted-but-unanswered responses.
// Depth is a power of two; pointers wrap naturally.
module resp_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rp_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Entry storage, not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= din_i;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop)  rp_q <= rp_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like responder: word memory, in-order response queue,
// and a configurable head-of-queue latency timer.
module sram_like_resp
   import sram_like_resp_pkg::*;
#(
   parameter int MEM_AW = DEF_MEM_AW,
   parameter int QDEPTH = DEF_QDEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            lat_cfg,
   sram_like_resp_if.slave       bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [31:0]       mem_q [2**MEM_AW];
   logic [MEM_AW-1:0] word_idx;
   logic              accept, pop, full, empty;
   logic [CW-1:0]     count;
   entry_t            push_e, head;
   logic [3:0]        tmr_q, tmr_d;
   logic              fresh_q, fresh_d;
   logic              new_head;
   logic              unused_w;

   assign word_idx = bus.addr[MEM_AW+1:2];
   assign unused_w = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

   assign bus.addr_ok = ~reset & ~full;
   assign accept      = bus.req & bus.addr_ok;

   // A just-pushed head waits one cycle before it may answer.
   assign bus.data_ok = ~reset & ~empty & (tmr_q == 4'd0) & ~fresh_q;
   assign pop         = bus.data_ok;
   assign bus.rdata   = (bus.data_ok & head.is_read) ? head.data : '0;

   // Read data is captured now so later writes cannot disturb it.
   assign push_e.is_read = ~bus.wr;
   assign push_e.data    = bus.wr ? '0 : mem_q[word_idx];

   assign new_head = (accept & empty)
                   | (pop & ((count > CW'(1)) | accept));

   resp_fifo #(
      .W     (ENTRY_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (accept),
      .pop_i   (pop),
      .din_i   (push_e),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   // Byte-lane writes at the acceptance edge.
   always_ff @(posedge clk) begin
      if (accept && bus.wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i])
               mem_q[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
         end
      end
   end

   // Next head timer: reload on head change, else count down.
   always_comb begin
      tmr_d   = tmr_q;
      fresh_d = 1'b0;
      if (new_head) begin
         tmr_d   = lat_cfg;
         fresh_d = accept & (empty | (pop & (count == CW'(1))));
      end else if (tmr_q != 4'd0 && !fresh_q) begin
         tmr_d = tmr_q - 4'd1;
      end
   end

   // Head timer state.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmr_q   <= 4'd0;
         fresh_q <= 1'b0;
      end else begin
         tmr_q   <= tmr_d;
         fresh_q <= fresh_d;
      end
   end

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: directed scenarios plus random
// traffic checked against a transaction-level reference model.
module tb_sram_like_resp;

   localparam int QDEPTH = 4;
   localparam int MEM_AW = 10;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] lat_cfg;
   int         cyc;
   int         checks;
   int         errors;
   int         last_due;
   exp_t       mq[$];
   logic [31:0] mm [int];

   sram_like_resp_if bus_if ();

   sram_like_resp #(
      .MEM_AW (MEM_AW),
      .QDEPTH (QDEPTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .lat_cfg (lat_cfg),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h cyc=%0d",
                tag, obs, exp, cyc);
      end
   endtask

   // Reference model: due cycle = max(accept edge, previous due)
   // + 1 + latency; data from model memory at acceptance.
   always @(negedge clk) begin
      logic exp_dok;
      logic exp_aok;
      int   idx;
      int   t;
      int   base;
      exp_t e;
      if (reset) begin
         chk("rst_addr_ok", {31'd0, bus_if.addr_ok}, 32'd0);
         chk("rst_data_ok", {31'd0, bus_if.data_ok}, 32'd0);
         chk("rst_rdata", bus_if.rdata, 32'd0);
         mq.delete();
         last_due = 0;
      end else begin
         if (mq.size() > 0 && mq[0].due < cyc) begin
            chk("late_resp", 32'(cyc), 32'(mq[0].due));
            void'(mq.pop_front());
         end
         exp_dok = (mq.size() > 0) && (mq[0].due == cyc);
         exp_aok = (mq.size() < QDEPTH);
         chk("addr_ok", {31'd0, bus_if.addr_ok}, {31'd0, exp_aok});
         chk("data_ok", {31'd0, bus_if.data_ok}, {31'd0, exp_dok});
         if (exp_dok) begin
            chk("rdata", bus_if.rdata, mq[0].data);
            void'(mq.pop_front());
         end else begin
            chk("rdata_idle", bus_if.rdata, 32'd0);
         end
         if (bus_if.req && exp_aok) begin
            idx = int'(bus_if.addr[MEM_AW+1:2]);
            t = cyc + 1;
            base = (last_due > t) ? last_due : t;
            e.due = base + 1 + int'(lat_cfg);
            last_due = e.due;
            if (bus_if.wr) begin
               e.data = 32'd0;
               for (int i = 0; i < 4; i++) begin
                  if (bus_if.wstrb[i])
                     mm[idx][8*i +: 8] = bus_if.wdata[8*i +: 8];
               end
            end else begin
               e.data = mm[idx];
            end
            mq.push_back(e);
         end
      end
   end

   task automatic issue(input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output int t);
      bus_if.req   = 1'b1;
      bus_if.wr    = w;
      bus_if.addr  = a;
      bus_if.wstrb = s;
      bus_if.wdata = d;
      bus_if.size  = 2'd2;
      t = -1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus_if.addr_ok) begin
            t = cyc + 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus_if.req = 1'b0;
      if (t < 0) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_resp(output int c, output logic [31:0] d);
      c = -1;
      d = 32'hx;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus_if.data_ok) begin
            c = cyc;
            d = bus_if.rdata;
            break;
         end
      end
      if (c < 0) chk("resp_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (mq.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("idle", 32'(mq.size()), 32'd0);
   endtask

   initial begin
      int          t, c, c0, acc, first_dok, ndok;
      int          acc_t [5];
      logic [31:0] d;
      checks = 0;
      errors = 0;
      last_due = 0;
      reset = 1'b1;
      lat_cfg = 4'd0;
      bus_if.req = 1'b0;
      bus_if.wr = 1'b0;
      bus_if.size = 2'd2;
      bus_if.addr = '0;
      bus_if.wstrb = '0;
      bus_if.wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Write 0x100, lat 0.
      c0 = cyc;
      issue(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, t);
      chk("wr_immediate_accept", 32'(t), 32'(c0 + 1));
      wait_resp(c, d);
      chk("wr_lat0", 32'(c), 32'(t + 1));
      chk("wr_rdata_zero", d, 32'd0);

      // Read 0x100, lat 3.
      lat_cfg = 4'd3;
      issue(1'b0, 32'h100, 4'h0, 32'h0, t);
      wait_resp(c, d);
      chk("rd_lat3", 32'(c), 32'(t + 4));
      chk("rd_deadbeef", d, 32'hDEADBEEF);

      // Partial write then read.
      lat_cfg = 4'd0;
      issue(1'b1, 32'h100, 4'b0010, 32'h11223344, t);
      wait_resp(c, d);
      issue(1'b1, 32'h100, 4'b0000, 32'hFFFFFFFF, t);
      wait_resp(c, d);
      chk("wstrb0_resp", d, 32'd0);
      issue(1'b0, 32'h100, 4'h0, 32'h0, t);
      wait_resp(c, d);
      chk("rd_partial", d, 32'hDEAD33EF);
      issue(1'b0, 32'hFFFF_F102, 4'h0, 32'h0, t);
      wait_resp(c, d);
      chk("rd_alias", d, 32'hDEAD33EF);

      // Read then write same word in consecutive cycles.
      issue(1'b1, 32'h104, 4'hF, 32'hA5A5A5A5, t);
      wait_resp(c, d);
      bus_if.req = 1'b1;
      bus_if.wr = 1'b0;
      bus_if.addr = 32'h104;
      @(negedge clk);
      chk("rw_acc_rd", {31'd0, bus_if.addr_ok}, 32'd1);
      @(posedge clk);
      #1;
      bus_if.wr = 1'b1;
      bus_if.wstrb = 4'hF;
      bus_if.wdata = 32'h5A5A1234;
      @(negedge clk);
      chk("rw_acc_wr", {31'd0, bus_if.addr_ok}, 32'd1);
      @(posedge clk);
      #1;
      bus_if.req = 1'b0;
      wait_resp(c, d);
      chk("rw_old_val", d, 32'hA5A5A5A5);
      wait_resp(c, d);
      chk("rw_wr_resp", d, 32'd0);
      issue(1'b0, 32'h104, 4'h0, 32'h0, t);
      wait_resp(c, d);
      chk("rw_new_val", d, 32'h5A5A1234);

      // Fill the queue with lat 15.
      wait_idle();
      lat_cfg = 4'd15;
      bus_if.req = 1'b1;
      bus_if.wr = 1'b0;
      bus_if.addr = 32'h100;
      acc = 0;
      first_dok = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus_if.data_ok && first_dok < 0) first_dok = cyc;
         if (bus_if.addr_ok) begin
            acc_t[acc] = cyc;
            acc++;
         end
         if (acc == 5) break;
      end
      @(posedge clk);
      #1;
      bus_if.req = 1'b0;
      chk("full_acc_count", 32'(acc), 32'd5);
      if (acc == 5) begin
         chk("full_4_b2b", 32'(acc_t[3]), 32'(acc_t[0] + 3));
         chk("full_first_dok", 32'(first_dok), 32'(acc_t[0] + 17));
         chk("full_5th_acc", 32'(acc_t[4]), 32'(first_dok + 1));
      end
      wait_idle();

      // Reset with two reads outstanding.
      issue(1'b0, 32'h100, 4'h0, 32'h0, t);
      issue(1'b0, 32'h104, 4'h0, 32'h0, t);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_addr_ok", {31'd0, bus_if.addr_ok}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_addr_ok", {31'd0, bus_if.addr_ok}, 32'd1);
      ndok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus_if.data_ok) ndok++;
      end
      chk("post_rst_no_dok", 32'(ndok), 32'd0);
      @(posedge clk);
      #1;

      // Prefill a random-traffic region.
      lat_cfg = 4'd0;
      for (int k = 0; k < 16; k++) begin
         issue(1'b1, 32'h200 + 32'(k * 4), 4'hF, $urandom, t);
      end
      wait_idle();

      // Random bursts, latency fixed within each burst.
      for (int b = 0; b < 6; b++) begin
         lat_cfg = (b == 0) ? 4'd0 : 4'($urandom_range(0, 3));
         for (int k = 0; k < 40; k++) begin
            bus_if.req = ($urandom_range(0, 3) != 0);
            bus_if.wr = 1'($urandom_range(0, 1));
            bus_if.size = 2'($urandom_range(0, 2));
            bus_if.addr = ($urandom & 32'hFFFF_F000) | 32'h200
                        | 32'($urandom_range(0, 15) * 4)
                        | 32'($urandom_range(0, 3));
            bus_if.wstrb = 4'($urandom);
            bus_if.wdata = $urandom;
            @(posedge clk);
            #1;
         end
         bus_if.req = 1'b0;
         wait_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 Parameter MEM_AW, default 10, meaning word-address width of internal memory (2^MEM_AW 32-bit words).
REQ-002 Parameter QDEPTH, default 4, meaning max accepted-but-unanswered transactions; power of two >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 req  input  1  initiator request valid.
REQ-006 wr  input  1  1 = write, 0 = read.
REQ-007 size  input  2  0 byte, 1 half, 2 word; informational only.
REQ-008 addr  input  32  byte address.
REQ-009 wstrb  input  4  byte-lane write enables (writes only).
REQ-010 wdata  input  32  write data.
REQ-011 lat_cfg  input  4  extra response delay in cycles (0..15).
REQ-012 addr_ok  output  1  request accepted this cycle when req & addr_ok.
REQ-013 data_ok  output  1  one-cycle response pulse, one per accepted request, in order.
REQ-014 rdata  output  32  read data, valid only while data_ok is high.

Function
REQ-015 Handshake: transaction accepted on rising edge where req=1 and addr_ok=1; addr_ok SHALL be combinational = ~reset & (count < QDEPTH).
REQ-016 Word index = addr[MEM_AW+1:2]; addr[31:MEM_AW+2] and addr[1:0] ignored (aliasing, no alignment fault).
REQ-017 Accepted write: memory bytes with wstrb[i]=1 updated from wdata[8i+7:8i] at acceptance edge; wstrb=0 writes nothing but still gets one data_ok.
REQ-018 Accepted read: word captured into response queue at acceptance edge, so a later-accepted write never alters an earlier read's data.
REQ-019 Read and write to same word accepted back-to-back: read after write returns the written value.
REQ-020 Response queue: FIFO of QDEPTH entries {is_read, data}; push on acceptance, pop on data_ok.
REQ-021 Head timer: loaded with lat_cfg when an entry becomes head (push into empty queue, or pop with non-empty remainder); decrements each cycle while nonzero.
REQ-022 data_ok SHALL be 1 exactly when queue non-empty and head timer = 0 and head has been head for at least one cycle; rdata = head data for reads, 32'h0 for writes; rdata = 0 when data_ok=0.
REQ-023 Latency: isolated transaction accepted at edge T yields data_ok in cycle T+1+lat_cfg; back-to-back with lat_cfg=0 yields one data_ok per cycle.
REQ-024 lat_cfg changes affect only entries that become head after the change.
REQ-025 Simultaneous push and pop permitted; count unchanged; only when count < QDEPTH before the edge (no full-queue bypass).
REQ-026 Full: count = QDEPTH forces addr_ok=0; req held by initiator is accepted in the cycle after the next pop.
REQ-027 Pointers wrap modulo QDEPTH; count range 0..QDEPTH.

Reset
REQ-028 While reset=1: addr_ok=0, data_ok=0, rdata=0; queue count, pointers, head timer cleared at the edge.
REQ-029 Reset mid-operation discards all outstanding entries; no data_ok for them after reset deasserts.
REQ-030 Memory contents not reset; writes never occur while reset=1.

Structure
REQ-031 Shared package holds size encodings (BYTE/HALF/WORD), default QDEPTH and MEM_AW, queue-entry field widths.
REQ-032 One sub-module: resp_fifo (synchronous FIFO, push/pop/full/empty/count, parameterised width and depth); memory and head timer stay in top.

Verification
REQ-033 Reset, then write word 0x100 = 32'hDEADBEEF wstrb=4'hF, lat_cfg=0 -> addr_ok=1 at accept, data_ok one cycle later, rdata=0.
REQ-034 Read 0x100 after REQ-033 with lat_cfg=3 -> data_ok exactly 4 cycles after acceptance, rdata=32'hDEADBEEF.
REQ-035 Write 0x100 wdata=32'h11223344 wstrb=4'b0010, then read -> rdata=32'hDEAD33EF.
REQ-036 lat_cfg=15, issue 5 back-to-back reads -> addr_ok low after 4th accept, 5th accepted the cycle after first data_ok; 5 data_ok in order with correct data.
REQ-037 Two reads outstanding, assert reset one cycle -> no data_ok afterward; addr_ok=0 during reset, 1 after.
REQ-038 Read 0x104 then write 0x104 accepted in consecutive cycles -> read returns old value, write applied.
